// File: rtl/aes_pkg.sv
// Shared AES datapath types, the GF(2^8) xtime primitive and column helpers.
package aes_pkg;

    localparam int unsigned STATE_W  = 128;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned NUM_COLS = 4;
    localparam logic [7:0]  AES_POLY = 8'h1B;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [COL_W-1:0]   col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    // Multiply by 2 in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Column c lives at [127-32c -: 32].
    function automatic col_t get_col(input state_t s, input logic [1:0] idx);
        col_t c;
        case (idx)
            2'd0: c = s[127:96];
            2'd1: c = s[95:64];
            2'd2: c = s[63:32];
            2'd3: c = s[31:0];
        endcase
        return c;
    endfunction

    function automatic state_t set_col(input state_t s, input logic [1:0] idx, input col_t c);
        state_t r;
        r = s;
        case (idx)
            2'd0: r[127:96] = c;
            2'd1: r[95:64]  = c;
            2'd2: r[63:32]  = c;
            2'd3: r[31:0]   = c;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for mix_columns_seq; the inv select exists only
// when MIX_COLUMNS_INV_EN is defined.
interface mix_columns_seq_if;

    logic            in_valid;
    logic            in_ready;
    aes_pkg::state_t in_state;
    logic            out_valid;
    logic            out_ready;
    aes_pkg::state_t out_state;
    logic            busy;
`ifdef MIX_COLUMNS_INV_EN
    logic            inv;

    modport master (
        output in_valid, in_state, out_ready, inv,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready, inv,
        output in_ready, out_valid, out_state, busy
    );
`else
    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
`endif

endinterface

// File: rtl/mix_column_unit.sv
// Combinational MixColumns on one 32-bit column (a0 in [31:24]).
// With MIX_COLUMNS_INV_EN defined, i_inv selects InvMixColumns.
module mix_column_unit
    import aes_pkg::*;
(
`ifdef MIX_COLUMNS_INV_EN
    input  logic i_inv,
`endif
    input  col_t i_col,
    output col_t o_col_c
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    col_t       w_fwd;

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_fwd = {
        xtime(w_a0) ^ mul3(w_a1)  ^ w_a2        ^ w_a3,
        w_a0        ^ xtime(w_a1) ^ mul3(w_a2)  ^ w_a3,
        w_a0        ^ w_a1        ^ xtime(w_a2) ^ mul3(w_a3),
        mul3(w_a0)  ^ w_a1        ^ w_a2        ^ xtime(w_a3)
    };

`ifdef MIX_COLUMNS_INV_EN
    col_t w_inv;

    // Inverse coefficients from chained xtime: 4x, 8x, then XOR combinations.
    function automatic logic [7:0] mul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    assign w_inv = {
        mule(w_a0) ^ mulb(w_a1) ^ muld(w_a2) ^ mul9(w_a3),
        mul9(w_a0) ^ mule(w_a1) ^ mulb(w_a2) ^ muld(w_a3),
        muld(w_a0) ^ mul9(w_a1) ^ mule(w_a2) ^ mulb(w_a3),
        mulb(w_a0) ^ muld(w_a1) ^ mul9(w_a2) ^ mule(w_a3)
    };

    assign o_col_c = i_inv ? w_inv : w_fwd;
`else
    assign o_col_c = w_fwd;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: COLS_PER_CYCLE columns per clock, one state in flight.
// Optional MIX_COLUMNS_INV_EN adds a per-transaction inverse-transform select.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input logic              clk,
    input logic              rst,
    mix_columns_seq_if.slave bus
);

    localparam int unsigned     CNT_W    = 2;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NUM_COLS - COLS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(COLS_PER_CYCLE);

    mc_state_e        r_state;
    mc_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    state_t           r_src;
    state_t           r_res;
    state_t           w_res_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             w_load;
    logic             r_inv;

    col_t w_col_in  [COLS_PER_CYCLE];
    col_t w_col_out [COLS_PER_CYCLE];

    // One column unit per lane; lane g handles column r_cnt+g.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        logic [CNT_W-1:0] w_idx;

        assign w_idx       = r_cnt + CNT_W'(g);
        assign w_col_in[g] = get_col(r_src, w_idx);

`ifdef MIX_COLUMNS_INV_EN
        mix_column_unit u_unit (
            .i_inv   (r_inv),
            .i_col   (w_col_in[g]),
            .o_col_c (w_col_out[g])
        );
`else
        mix_column_unit u_unit (
            .i_col   (w_col_in[g]),
            .o_col_c (w_col_out[g])
        );
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update selection.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_res_nxt       = r_res;
        w_out_valid_nxt = r_out_valid;
        w_load          = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    w_res_nxt = set_col(w_res_nxt, r_cnt + CNT_W'(g), w_col_out[g]);
                end
                if (r_cnt == LAST_GRP) begin
                    w_state_nxt     = DONE;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_STEP;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers; the source is captured only at the input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_src       <= '0;
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_res       <= w_res_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_load) begin
                r_src <= bus.in_state;
`ifdef MIX_COLUMNS_INV_EN
                r_inv <= bus.inv;
`endif
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_res;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: one-column, two-column and four-column builds.
`timescale 1ns/1ps
module tb_mix_columns_seq;
    import aes_pkg::*;

    localparam state_t V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam state_t V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam state_t V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_80808080;
    localparam state_t V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_80808080;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mix_columns_seq_if f1 ();
    mix_columns_seq_if f2 ();
    mix_columns_seq_if f4 ();

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(f1.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(f2.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(f4.slave));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake a state into dut1 and wait (bounded) for out_valid.
    task automatic start1(input state_t s, input string tag);
        int lat;
        check_eq({tag, "_in_ready"}, 128'(f1.in_ready), 128'(1));
        f1.in_valid = 1'b1;
        f1.in_state = s;
        step();
        f1.in_valid = 1'b0;
        lat = 0;
        while (!f1.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check_eq({tag, "_latency"}, 128'(lat), 128'(4));
    endtask

    task automatic run1(input state_t s, input string tag, output state_t res);
        start1(s, tag);
        res = f1.out_state;
        f1.out_ready = 1'b1;
        step();
        f1.out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 128'(f1.out_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t res, held, res2, res4;
        int     lat2, lat4;
        logic   any_valid;

        rst = 1'b1;
        f1.in_valid = 1'b0; f1.in_state = '0; f1.out_ready = 1'b0;
        f2.in_valid = 1'b0; f2.in_state = '0; f2.out_ready = 1'b1;
        f4.in_valid = 1'b0; f4.in_state = '0; f4.out_ready = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
        f1.inv = 1'b0; f2.inv = 1'b0; f4.inv = 1'b0;
`endif
        step();
        f1.in_valid = 1'b1;
        f1.in_state = V2_IN;
        step();
        f1.in_valid = 1'b0;
        rst = 1'b0;
        check_eq("rst_out_valid", 128'(f1.out_valid), 128'(0));
        check_eq("rst_out_state", f1.out_state, 128'h0);
        check_eq("rst_in_ready", 128'(f1.in_ready), 128'(1));
        check_eq("rst_busy", 128'(f1.busy), 128'(0));

        // Basic vectors.
        run1(V1_IN, "t1", res);
        check_eq("t1_out_state", res, V1_OUT);
        run1(V2_IN, "t2", res);
        check_eq("t2_out_state", res, V2_OUT);

        // Backpressure in DONE with a competing input held high.
        start1(V2_IN, "t3a");
        held = f1.out_state;
        check_eq("t3a_out_state", held, V2_OUT);
        f1.in_valid = 1'b1;
        f1.in_state = V1_IN;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("t3_hold_valid", 128'(f1.out_valid), 128'(1));
            check_eq("t3_hold_state", f1.out_state, held);
            check_eq("t3_hold_in_ready", 128'(f1.in_ready), 128'(0));
            check_eq("t3_hold_busy", 128'(f1.busy), 128'(1));
        end
        f1.out_ready = 1'b1;
        step();
        f1.out_ready = 1'b0;
        check_eq("t3_release_valid", 128'(f1.out_valid), 128'(0));
        check_eq("t3_release_in_ready", 128'(f1.in_ready), 128'(1));
        check_eq("t3_release_state", f1.out_state, held);
        start1(V1_IN, "t3b");
        check_eq("t3b_out_state", f1.out_state, V1_OUT);
        f1.out_ready = 1'b1;
        step();
        f1.out_ready = 1'b0;

        // Reset in the second RUN cycle aborts the transaction.
        f1.in_valid = 1'b1;
        f1.in_state = V2_IN;
        step();
        f1.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t4_out_valid", 128'(f1.out_valid), 128'(0));
        check_eq("t4_out_state", f1.out_state, 128'h0);
        check_eq("t4_in_ready", 128'(f1.in_ready), 128'(1));
        check_eq("t4_busy", 128'(f1.busy), 128'(0));
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            any_valid = any_valid | f1.out_valid;
        end
        check_eq("t4_no_output", 128'(any_valid), 128'(0));
        run1(V1_IN, "t4b", res);
        check_eq("t4b_out_state", res, V1_OUT);

        // Wider lanes: two and four columns per clock.
        check_eq("t5_in_ready2", 128'(f2.in_ready), 128'(1));
        check_eq("t5_in_ready4", 128'(f4.in_ready), 128'(1));
        f2.in_valid = 1'b1; f2.in_state = V1_IN;
        f4.in_valid = 1'b1; f4.in_state = V1_IN;
        step();
        f2.in_valid = 1'b0;
        f4.in_valid = 1'b0;
        lat2 = -1; lat4 = -1; res2 = '0; res4 = '0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (f2.out_valid && lat2 < 0) begin
                lat2 = c;
                res2 = f2.out_state;
            end
            if (f4.out_valid && lat4 < 0) begin
                lat4 = c;
                res4 = f4.out_state;
            end
        end
        check_eq("t5_latency2", 128'(lat2), 128'(2));
        check_eq("t5_latency4", 128'(lat4), 128'(1));
        check_eq("t5_out_state2", res2, V1_OUT);
        check_eq("t5_out_state4", res4, V1_OUT);
        check_eq("t5_idle2", 128'(f2.in_ready), 128'(1));
        check_eq("t5_idle4", 128'(f4.in_ready), 128'(1));

`ifdef MIX_COLUMNS_INV_EN
        // Inverse transform and forward/inverse round trips.
        f1.inv = 1'b1;
        run1(V1_OUT, "t6", res);
        check_eq("t6_out_state", res, V1_IN);
        for (int k = 0; k < 4; k++) begin
            state_t orig, mid;
            orig = {$urandom, $urandom, $urandom, $urandom};
            f1.inv = 1'b0;
            run1(orig, "t6_fwd", mid);
            f1.inv = 1'b1;
            run1(mid, "t6_inv", res);
            check_eq("t6_round_trip", res, orig);
        end
        f1.inv = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Sequential AES MixColumns stage. It consumes the 128-bit state produced by ShiftRows and feeds AddRoundKey.
- Processes COLS_PER_CYCLE columns per clock, trading area for latency.
- Multiplies each column by the fixed GF(2^8) matrix, built from xtime multiply-by-2 primitives.
- valid/ready handshake on both sides; holds one state at a time.

Parameters:
COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4; compute latency = 4/COLS_PER_CYCLE cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_state is valid
in_ready  output  1  block can accept a state; high only in IDLE
in_state  input  128  input state; byte k at [127-8k -: 8]; column c = bytes 4c..4c+3; column 0 at [127:96]
out_valid  output  1  out_state is valid
out_ready  input  1  downstream accepts out_state
out_state  output  128  mixed state, same byte ordering as in_state
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state <- IDLE, column counter <- 0.
  - out_valid <- 0, out_state <- 128'h0.
  - in_valid is ignored in any cycle where rst=1.
  - Reset mid-operation aborts the transaction; no output is produced for the aborted state.
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
- Column math for a0..a3, with 3·x = xtime(x)^x:
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - All arithmetic is 8-bit XOR; no carries.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid: latch in_state into the source register, counter <- 0, go to RUN.
  - RUN: each cycle, write columns counter..counter+COLS_PER_CYCLE-1 of the result register; counter += COLS_PER_CYCLE. After the last group, go to DONE and set out_valid=1 on the same edge.
  - DONE: out_state and out_valid are held stable while out_ready=0. On out_ready=1, out_valid <- 0 and go to IDLE.
- Latency: input handshake to out_valid is exactly 4/COLS_PER_CYCLE cycles. Max throughput is one state per 4/COLS_PER_CYCLE+2 cycles.
- in_ready=0 in RUN and DONE. in_valid asserted there is not consumed and must be held by upstream.
- out_state keeps its last value after the output handshake until the next result is written. It is only meaningful while out_valid=1.
- Counter wraps to 0 on entry to RUN; no other wrap-around.
- out_ready asserted outside DONE has no effect.

Optional Feature:
MIX_COLUMNS_INV_EN.
- Defined:
  - Adds input port inv (1 bit), latched together with in_state at the input handshake.
  - inv=1 selects InvMixColumns with coefficients 0e/0b/0d/09. These are built from chained xtime: 4x=xtime(xtime(x)), 8x=xtime(4x), 9x=8x^x, 0b=8x^2x^x, 0d=8x^4x^x, 0e=8x^4x^2x.
  - Mid-transaction changes to inv are ignored.
- Undefined: port inv is absent; forward transform only; no inverse logic is synthesised.
- Latency is identical in both builds.

Decomposition:
- Shared package aes_pkg:
  - typedef state_t (logic [127:0]) and col_t (logic [31:0]).
  - constant AES_POLY = 8'h1B.
  - function xtime.
  - enum mc_state_e {IDLE, RUN, DONE}.
- Sub-module mix_column_unit: combinational, one 32-bit column in, one 32-bit column out, plus an inv input when MIX_COLUMNS_INV_EN is defined. Instantiate COLS_PER_CYCLE copies.

Test Plan:
1. Reset, COLS_PER_CYCLE=1, in_state=db135345_f20a225c_01010101_c6c6c6c6 -> out_valid exactly 4 cycles after handshake; out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6.
2. in_state=d4d4d4d5_2d26314c_00000000_80808080 -> out_state=d5d5d7d6_4d7ebdf8_00000000_80808080. Covers xtime reduction on the 0x80 bytes and the all-zero column.
3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state and out_valid stable, in_ready=0; a new in_valid is not consumed until after out_ready=1.
4. Assert rst in the 2nd RUN cycle -> next cycle out_valid=0, out_state=0, in_ready=1; a following transaction produces the correct result.
5. Sweep COLS_PER_CYCLE=2 and 4 with test 1 stimulus -> same out_state; latency 2 and 1 cycles respectively.
6. MIX_COLUMNS_INV_EN, inv=1, in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_state=db135345_f20a225c_01010101_c6c6c6c6. Randomised forward-then-inverse round trip returns the original state.
